// File: rtl/gifplayer_pkg.sv
// rtl/gifplayer_pkg.sv - shared types and constants for the SRAM frame reader
//
// Contents:
//   state_t  reader FSM states (IDLE, FETCH, DRAIN)
//   SRAM_AW  SRAM word address width
//   SRAM_DW  SRAM data width
//   PIX_W    palette index width
package gifplayer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;
  localparam int PIX_W   = 8;

endpackage

// File: rtl/frame_word_fifo.sv
// rtl/frame_word_fifo.sv - synchronous word FIFO with occupancy count
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data this cycle (caller never pushes when full)
//   push_data  in   WIDTH-bit write word
//   pop        in   drop the head word this cycle (caller never pops when empty)
//   pop_data   out  head word, valid while count != 0
//   count      out  number of stored words, 0..DEPTH
module frame_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sram_frame_reader.sv
// rtl/sram_frame_reader.sv - fetches a frame from shared async SRAM as an 8-bit pixel stream
//
// Optional feature: SRAM_FRAME_READER_LOOP_EN - when defined, the frame is
// re-fetched endlessly from the latched base and frame_done pulses per frame.
//
// Ports:
//   clk_clk, reset_reset_n        clock, asynchronous active-low reset
//   frame_start, frame_base       start pulse (honoured in IDLE) and word base address
//   busy, frame_done              frame in progress, one-cycle completion pulse
//   sram_req, sram_gnt            bus request to / grant from the SRAM arbiter
//   sram_ADDR, sram_DQ            read address, read data
//   sram_CE_N/OE_N/WE_N/LB_N/UB_N SRAM strobes (WE_N always high)
//   pix_data/valid/ready          pixel stream handshake
//   pix_eol, pix_eof              last pixel of line / frame
module sram_frame_reader
  import gifplayer_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               frame_start,
  input  logic [SRAM_AW-1:0] frame_base,
  output logic               busy,
  output logic               frame_done,
  output logic               sram_req,
  input  logic               sram_gnt,
  output logic [SRAM_AW-1:0] sram_ADDR,
  input  logic [SRAM_DW-1:0] sram_DQ,
  output logic               sram_CE_N,
  output logic               sram_OE_N,
  output logic               sram_WE_N,
  output logic               sram_LB_N,
  output logic               sram_UB_N,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_eol,
  output logic               pix_eof
);

`ifdef SRAM_FRAME_READER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int NW = WIDTH * HEIGHT / 2;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  state_t             state;
  state_t             next_state;
  logic [SRAM_AW-1:0] base;
  logic [KW-1:0]      k;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic               hi;          // next pixel comes from the high byte of the head word
  logic [CW-1:0]      fifo_count;
  logic [SRAM_DW-1:0] fifo_word;
  logic               start;
  logic               rd;
  logic               last_word;
  logic               accept;
  logic               pop;

  frame_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_DW)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (rd),
    .push_data (sram_DQ),
    .pop       (pop),
    .pop_data  (fifo_word),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = (state == IDLE) && frame_start;
    busy       = (state != IDLE);
    // Request drops combinationally once the FIFO is full, so a read is
    // never issued without room for its word.
    sram_req   = (state == FETCH) && (fifo_count != C_FULL);
    rd         = sram_req && sram_gnt;
    last_word  = rd && (k == K_LAST);

    sram_ADDR  = rd ? (base + SRAM_AW'(k)) : '0;
    sram_CE_N  = !rd;
    sram_OE_N  = !rd;
    sram_LB_N  = !rd;
    sram_UB_N  = !rd;
    sram_WE_N  = 1'b1;

    pix_valid  = (fifo_count != '0);
    accept     = pix_valid && pix_ready;
    pop        = accept && hi;
    pix_data   = '0;
    if (pix_valid) pix_data = hi ? fifo_word[15:8] : fifo_word[7:0];
    pix_eol    = pix_valid && (x == X_LAST);
    pix_eof    = pix_eol && (y == Y_LAST);

    case (state)
      IDLE:    if (frame_start) next_state = FETCH;
      FETCH:   if (last_word && !LOOP_EN) next_state = DRAIN;
      // The last pixel pops the last word, so the FIFO is empty after this edge.
      DRAIN:   if (accept && pix_eof) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      base       <= '0;
      k          <= '0;
      x          <= '0;
      y          <= '0;
      hi         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && pix_eof && (LOOP_EN || (state == DRAIN));
      if (start) begin
        base <= frame_base;
        k    <= '0;
        x    <= '0;
        y    <= '0;
        hi   <= 1'b0;
      end else begin
        // k wraps after the last word; in single-shot mode it is unused afterwards.
        if (rd) k <= last_word ? '0 : k + 1'b1;
        if (accept) begin
          hi <= !hi;
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
      end
    end
  end

endmodule
